// File: rtl/picorv32_pcpi_fp_arbiter_if.sv
// Bus bundles for picorv32_pcpi_fp_arbiter.
//   picorv32_pcpi_fp_arbiter_pcpi_if : core-side PCPI port (core = master, arbiter = slave)
//   picorv32_pcpi_fp_arbiter_unit_if : FP-unit side bank bus (arbiter = master, units = slave)

interface picorv32_pcpi_fp_arbiter_pcpi_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

interface picorv32_pcpi_fp_arbiter_unit_if #(
  parameter int NUM_UNITS = 4
);
  logic [NUM_UNITS-1:0]    u_valid;
  logic [31:0]             u_insn;
  logic [31:0]             u_rs1;
  logic [31:0]             u_rs2;
  logic [NUM_UNITS-1:0]    u_wr;
  logic [32*NUM_UNITS-1:0] u_rd;
  logic [NUM_UNITS-1:0]    u_ready;

  modport master (
    output u_valid, u_insn, u_rs1, u_rs2,
    input  u_wr, u_rd, u_ready
  );

  modport slave (
    input  u_valid, u_insn, u_rs1, u_rs2,
    output u_wr, u_rd, u_ready
  );
endinterface

// File: rtl/picorv32_pcpi_fp_arbiter.sv
// picorv32_pcpi_fp_arbiter
// Decodes custom-0 R-type instructions from the picorv32 PCPI port and routes
// each accepted one to exactly one multi-cycle FP unit (unit i serves
// funct7 = FUNCT7_BASE + i). The unit's single-cycle result pulse is turned
// into one clean PCPI response. The arbiter holds pcpi_wait for the whole
// operation so the core never times out on long FP latencies.
//
// Optional feature: define PCPI_FP_ARB_TIMEOUT_EN to enable the unit watchdog.
// When it expires, the operation is completed with a quiet NaN and the
// sticky err_timeout flag is set. Without the macro the arbiter waits
// indefinitely and err_timeout is tied low.

module picorv32_pcpi_fp_arbiter #(
  parameter int         NUM_UNITS   = 4,
  parameter logic [6:0] FUNCT7_BASE = 7'd1,
  parameter int         TIMEOUT     = 255
) (
  input  logic                                      clk,
  input  logic                                      reset,
  picorv32_pcpi_fp_arbiter_pcpi_if.slave            pcpi,
  picorv32_pcpi_fp_arbiter_unit_if.master           ubus,
  output logic [31:0]                               op_count,
  output logic                                      err_timeout
);

  localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;
  localparam logic [31:0] QNAN        = 32'h7FC0_0000;

  // Out-of-range configurations are rejected at elaboration.
  if (NUM_UNITS < 1 || NUM_UNITS > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("picorv32_pcpi_fp_arbiter: NUM_UNITS must be 1..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_UNIT = 2'd1,
    S_RESPOND   = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  state_t                 state_q;
  logic [2:0]             sel_q;
  logic [NUM_UNITS-1:0]   u_valid_q;
  logic [31:0]            u_insn_q;
  logic [31:0]            u_rs1_q;
  logic [31:0]            u_rs2_q;
  logic                   pcpi_wr_q;
  logic [31:0]            pcpi_rd_q;
  logic                   pcpi_wait_q;
  logic                   pcpi_ready_q;
  logic [31:0]            op_count_q;

`ifdef PCPI_FP_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);
  logic [7:0]             tmo_cnt_q;
  logic                   err_timeout_q;
`endif

  // Decode: funct7 offset relative to the base is computed one bit wider so
  // funct7 values below the base cannot alias into the valid range.
  logic [6:0]             funct7;
  logic [7:0]             f7_off;
  logic                   in_range;
  logic                   match;
  logic [2:0]             dec_sel;
  logic [NUM_UNITS-1:0]   u_valid_d;

  assign funct7   = pcpi.pcpi_insn[31:25];
  assign f7_off   = {1'b0, funct7} - {1'b0, FUNCT7_BASE};
  assign in_range = (funct7 >= FUNCT7_BASE) && (f7_off < 8'(NUM_UNITS));
  assign match    = pcpi.pcpi_valid && (pcpi.pcpi_insn[6:0] == OPC_CUSTOM0) && in_range;
  assign dec_sel  = f7_off[2:0];

  // One-hot request vector for the unit addressed by the incoming instruction.
  always_comb begin
    u_valid_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      u_valid_d[i] = (dec_sel == 3'(i));
    end
  end

  // Result mux: only the selected unit's ready/wr/rd are observed; pulses
  // from other units fall through to nothing.
  logic                   sel_ready;
  logic                   sel_wr;
  logic [31:0]            sel_rd;

  always_comb begin
    sel_ready = 1'b0;
    sel_wr    = 1'b0;
    sel_rd    = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == 3'(i)) begin
        sel_ready = ubus.u_ready[i];
        sel_wr    = ubus.u_wr[i];
        sel_rd    = ubus.u_rd[32*i +: 32];
      end
    end
  end

  // Sequencer FSM; every output towards core and units is a register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      u_valid_q    <= '0;
      u_insn_q     <= '0;
      u_rs1_q      <= '0;
      u_rs2_q      <= '0;
      pcpi_wr_q    <= 1'b0;
      pcpi_rd_q    <= '0;
      pcpi_wait_q  <= 1'b0;
      pcpi_ready_q <= 1'b0;
      op_count_q   <= '0;
`ifdef PCPI_FP_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      // Response strobes are single-cycle; only the WAIT_UNIT exit raises them.
      pcpi_ready_q <= 1'b0;
      pcpi_wr_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (match) begin
            sel_q       <= dec_sel;
            u_insn_q    <= pcpi.pcpi_insn;
            u_rs1_q     <= pcpi.pcpi_rs1;
            u_rs2_q     <= pcpi.pcpi_rs2;
            u_valid_q   <= u_valid_d;
            pcpi_wait_q <= 1'b1;
`ifdef PCPI_FP_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
            state_q     <= S_WAIT_UNIT;
          end
        end

        S_WAIT_UNIT: begin
          // A unit answer in the expiry cycle wins over the watchdog.
          if (sel_ready) begin
            u_valid_q    <= '0;
            pcpi_wait_q  <= 1'b0;
            pcpi_ready_q <= 1'b1;
            pcpi_wr_q    <= sel_wr;
            pcpi_rd_q    <= sel_rd;
            state_q      <= S_RESPOND;
          end
`ifdef PCPI_FP_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LIM) begin
            u_valid_q     <= '0;
            pcpi_wait_q   <= 1'b0;
            pcpi_ready_q  <= 1'b1;
            pcpi_wr_q     <= 1'b1;
            pcpi_rd_q     <= QNAN;
            err_timeout_q <= 1'b1;
            state_q       <= S_RESPOND;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end

        S_RESPOND: begin
          op_count_q <= op_count_q + 32'd1;
          state_q    <= S_DRAIN;
        end

        // Stay here while the core still presents the finished instruction.
        S_DRAIN: begin
          if (!pcpi.pcpi_valid) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pcpi.pcpi_wr    = pcpi_wr_q;
  assign pcpi.pcpi_rd    = pcpi_rd_q;
  assign pcpi.pcpi_wait  = pcpi_wait_q;
  assign pcpi.pcpi_ready = pcpi_ready_q;

  assign ubus.u_valid    = u_valid_q;
  assign ubus.u_insn     = u_insn_q;
  assign ubus.u_rs1      = u_rs1_q;
  assign ubus.u_rs2      = u_rs2_q;

  assign op_count        = op_count_q;

`ifdef PCPI_FP_ARB_TIMEOUT_EN
  assign err_timeout     = err_timeout_q;
`else
  assign err_timeout     = 1'b0;
  // QNAN is only needed for forced completions.
  logic unused_qnan;
  assign unused_qnan     = ^QNAN;
`endif

endmodule
